// File: rtl/pll_lock_supervisor_if.sv
// PLL lock input plus the staged reset / status outputs of pll_lock_supervisor.
// Defining PLL_AUTO_RESET_EN adds the pll_rst request line.
interface pll_lock_supervisor_if #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 8
);
  logic                  lock;
  logic [NUM_STAGES-1:0] rst_out;
  logic                  pll_ready;
  logic [CNT_W-1:0]      lock_lost_cnt;
  logic [1:0]            state;

`ifdef PLL_AUTO_RESET_EN
  logic                  pll_rst;

  modport master (input lock, output rst_out, pll_ready, lock_lost_cnt, state, pll_rst);
  modport slave  (output lock, input rst_out, pll_ready, lock_lost_cnt, state, pll_rst);
`else
  modport master (input lock, output rst_out, pll_ready, lock_lost_cnt, state);
  modport slave  (output lock, input rst_out, pll_ready, lock_lost_cnt, state);
`endif
endinterface

// File: rtl/pll_lock_supervisor.sv
// Debounces the PLL lock and releases lock-qualified staged resets, bit 0 first.
// Optional PLL_AUTO_RESET_EN: pulses pll_rst when lock never arrives in WAIT_LOCK.
module pll_lock_supervisor #(
  parameter int NUM_STAGES  = 4,
  parameter int STABLE_CYC  = 1000,
  parameter int STAGE_GAP   = 16,
  parameter int CNT_W       = 8
`ifdef PLL_AUTO_RESET_EN
  ,
  parameter int TIMEOUT_CYC = 50000,
  parameter int PLL_RST_CYC = 10
`endif
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  pll_lock_supervisor_if.master bus
);

  localparam int RELEASE_END = NUM_STAGES * STAGE_GAP;
  localparam int STABLE_W    = $clog2(STABLE_CYC + 1);
  localparam int GAP_W       = $clog2(RELEASE_END + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  logic [1:0]            sync_q;
  logic                  lock_s;
  state_e                state_q, state_d;
  logic [STABLE_W-1:0]   stable_q, stable_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
  logic                  ready_q, ready_d;
  logic [CNT_W-1:0]      lost_q, lost_d;

  // lock is asynchronous to sys_clk; only the second flop may feed decisions
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.lock};
    end
  end

  assign lock_s = sync_q[1];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= WAIT_LOCK;
      stable_q  <= '0;
      gap_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      lost_q    <= '0;
    end else begin
      state_q   <= state_d;
      stable_q  <= stable_d;
      gap_q     <= gap_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      lost_q    <= lost_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stable_d  = stable_q;
    gap_d     = gap_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    lost_d    = lost_q;

    unique case (state_q)
      WAIT_LOCK: begin
        rst_out_d = '1;
        ready_d   = 1'b0;
        gap_d     = '0;
        stable_d  = '0;
        if (lock_s) begin
          state_d  = STABLE;
          stable_d = STABLE_W'(1);
        end
      end

      STABLE: begin
        if (!lock_s) begin
          state_d  = WAIT_LOCK;
          stable_d = '0;
        end else begin
          stable_d = stable_q + 1'b1;
          if (stable_d == STABLE_W'(STABLE_CYC)) begin
            state_d  = RELEASE;
            stable_d = '0;
            gap_d    = '0;
          end
        end
      end

      RELEASE, RUN: begin
        // A lock drop wins over any stage release due on this same edge
        if (!lock_s) begin
          state_d   = WAIT_LOCK;
          rst_out_d = '1;
          ready_d   = 1'b0;
          gap_d     = '0;
          if (lost_q != {CNT_W{1'b1}}) begin
            lost_d = lost_q + 1'b1;
          end
        end else if (state_q == RELEASE) begin
          gap_d = gap_q + 1'b1;
          for (int k = 0; k < NUM_STAGES; k++) begin
            if (gap_d == GAP_W'((k + 1) * STAGE_GAP)) begin
              rst_out_d[k] = 1'b0;
            end
          end
          if (gap_d == GAP_W'(RELEASE_END)) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = WAIT_LOCK;
      end
    endcase
  end

  assign bus.rst_out       = rst_out_q;
  assign bus.pll_ready     = ready_q;
  assign bus.lock_lost_cnt = lost_q;
  assign bus.state         = state_q;

`ifdef PLL_AUTO_RESET_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int PR_W = $clog2(PLL_RST_CYC + 1);

  logic [TO_W-1:0] tmo_q, tmo_d;
  logic [PR_W-1:0] pulse_q, pulse_d;
  logic            pll_rst_q, pll_rst_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tmo_q     <= '0;
      pulse_q   <= '0;
      pll_rst_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      pulse_q   <= pulse_d;
      pll_rst_q <= pll_rst_d;
    end
  end

  // The pulse runs to full width regardless of FSM activity; timer restarts after it
  always_comb begin
    tmo_d     = tmo_q;
    pulse_d   = pulse_q;
    pll_rst_d = pll_rst_q;

    if (pll_rst_q) begin
      tmo_d = '0;
      if (pulse_q == PR_W'(PLL_RST_CYC)) begin
        pll_rst_d = 1'b0;
        pulse_d   = '0;
      end else begin
        pulse_d = pulse_q + 1'b1;
      end
    end else if (state_q == WAIT_LOCK) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_d == TO_W'(TIMEOUT_CYC)) begin
        tmo_d     = '0;
        pll_rst_d = 1'b1;
        pulse_d   = PR_W'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  assign bus.pll_rst = pll_rst_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomized bench for pll_lock_supervisor against a timeline-based reference model.
// Also covers the PLL_AUTO_RESET_EN pulse behaviour when that macro is defined.
module tb_pll_lock_supervisor;

  localparam int NUM_STAGES = 4;
  localparam int STABLE_CYC = 8;
  localparam int STAGE_GAP  = 4;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef PLL_AUTO_RESET_EN
  localparam int TIMEOUT_CYC = 40;
  localparam int PLL_RST_CYC = 3;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  pll_lock_supervisor_if #(.NUM_STAGES(NUM_STAGES), .CNT_W(CNT_W)) busIf ();

  pll_lock_supervisor #(
    .NUM_STAGES (NUM_STAGES),
    .STABLE_CYC (STABLE_CYC),
    .STAGE_GAP  (STAGE_GAP),
    .CNT_W      (CNT_W)
`ifdef PLL_AUTO_RESET_EN
    ,
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .PLL_RST_CYC(PLL_RST_CYC)
`endif
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (busIf)
  );

  always #5 sys_clk = ~sys_clk;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: lock history plus the edge at which debounce began
  bit lockHist[$];
  bit armed     = 1'b0;
  int armEdge   = 0;
  int lossCnt   = 0;
  int edgeNum   = 0;
  int tStart    = 0;
  int pStart    = -1000;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", tag, edgeNum, observed, expected);
    end
  endtask

  function automatic void modelEdge(input bit lockIn, input bit rstIn);
    bit lsBefore;
    bit wasArmed;
    edgeNum++;
    if (rstIn) begin
      lockHist.delete();
      armed   = 1'b0;
      lossCnt = 0;
      tStart  = edgeNum;
      pStart  = -1000;
      return;
    end
    lsBefore = (lockHist.size() >= 2) ? lockHist[lockHist.size() - 2] : 1'b0;
    wasArmed = armed;
`ifdef PLL_AUTO_RESET_EN
    if (edgeNum - 1 >= pStart && edgeNum - 1 < pStart + PLL_RST_CYC) begin
      if (edgeNum == pStart + PLL_RST_CYC) tStart = edgeNum;
    end else if (wasArmed) begin
      tStart = edgeNum;
    end else if (edgeNum - tStart == TIMEOUT_CYC) begin
      pStart = edgeNum;
    end
`endif
    if (wasArmed) begin
      if (!lsBefore) begin
        if (edgeNum - 1 >= armEdge + STABLE_CYC - 1 && lossCnt < CNT_MAX) lossCnt++;
        armed = 1'b0;
      end
    end else if (lsBefore) begin
      armed   = 1'b1;
      armEdge = edgeNum;
    end
    lockHist.push_back(lockIn);
    if (lockHist.size() > 4) void'(lockHist.pop_front());
  endfunction

  task automatic stepCycle();
    int rel;
    logic [1:0] eSt;
    logic [NUM_STAGES-1:0] eRst;
    logic eRdy;
    @(posedge sys_clk);
    modelEdge(busIf.lock, sys_rst);
    #1;
    eSt  = 2'd0;
    eRst = '1;
    eRdy = 1'b0;
    if (armed) begin
      rel = armEdge + STABLE_CYC - 1;
      if (edgeNum < rel) eSt = 2'd1;
      else if (edgeNum >= rel + NUM_STAGES * STAGE_GAP) begin
        eSt  = 2'd3;
        eRdy = 1'b1;
      end else eSt = 2'd2;
      for (int k = 0; k < NUM_STAGES; k++)
        if (edgeNum >= rel + (k + 1) * STAGE_GAP) eRst[k] = 1'b0;
    end
    checkOutput("rst_out", 32'(busIf.rst_out), 32'(eRst));
    checkOutput("pll_ready", 32'(busIf.pll_ready), 32'(eRdy));
    checkOutput("lock_lost_cnt", 32'(busIf.lock_lost_cnt), 32'(lossCnt));
    checkOutput("state", 32'(busIf.state), 32'(eSt));
`ifdef PLL_AUTO_RESET_EN
    checkOutput("pll_rst", 32'(busIf.pll_rst),
                32'((edgeNum >= pStart && edgeNum < pStart + PLL_RST_CYC) ? 1 : 0));
`endif
  endtask

  task automatic applyStimulus(input bit lockVal, input bit rstVal, input int cycles);
    busIf.lock = lockVal;
    sys_rst    = rstVal;
    repeat (cycles) stepCycle();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    busIf.lock = 1'b0;

    applyStimulus(0, 1, 5);
    checkOutput("tp1 rst_out", 32'(busIf.rst_out), 32'hF);
    checkOutput("tp1 pll_ready", 32'(busIf.pll_ready), 32'h0);
    checkOutput("tp1 lock_lost_cnt", 32'(busIf.lock_lost_cnt), 32'h0);
    checkOutput("tp1 state", 32'(busIf.state), 32'h0);

    // Nominal release schedule counted from the first edge sampling lock high
    applyStimulus(1, 0, 13);
    checkOutput("tp2 edge13 rst_out", 32'(busIf.rst_out), 32'hF);
    stepCycle();
    checkOutput("tp2 edge14 rst_out", 32'(busIf.rst_out), 32'hE);
    applyStimulus(1, 0, 3);
    stepCycle();
    checkOutput("tp2 edge18 rst_out", 32'(busIf.rst_out), 32'hC);
    applyStimulus(1, 0, 3);
    stepCycle();
    checkOutput("tp2 edge22 rst_out", 32'(busIf.rst_out), 32'h8);
    applyStimulus(1, 0, 3);
    checkOutput("tp2 edge25 pll_ready", 32'(busIf.pll_ready), 32'h0);
    stepCycle();
    checkOutput("tp2 edge26 rst_out", 32'(busIf.rst_out), 32'h0);
    checkOutput("tp2 edge26 pll_ready", 32'(busIf.pll_ready), 32'h1);
    checkOutput("tp2 edge26 state", 32'(busIf.state), 32'h3);

    // Debounce glitch restarts the schedule from the second rise
    applyStimulus(0, 1, 2);
    applyStimulus(1, 0, 5);
    applyStimulus(0, 0, 2);
    busIf.lock = 1'b1;
    stepCycle();
    checkOutput("tp3 state back to wait", 32'(busIf.state), 32'h0);
    applyStimulus(1, 0, 12);
    checkOutput("tp3 edge13 rst_out", 32'(busIf.rst_out), 32'hF);
    stepCycle();
    checkOutput("tp3 edge14 rst_out", 32'(busIf.rst_out), 32'hE);
    checkOutput("tp3 lock_lost_cnt", 32'(busIf.lock_lost_cnt), 32'h0);

    // Loss in RUN, then re-lock with the nominal timing
    applyStimulus(1, 0, 12);
    checkOutput("tp4 in run", 32'(busIf.state), 32'h3);
    applyStimulus(0, 0, 1);
    busIf.lock = 1'b1;
    stepCycle();
    checkOutput("tp4 still run", 32'(busIf.state), 32'h3);
    stepCycle();
    checkOutput("tp4 loss rst_out", 32'(busIf.rst_out), 32'hF);
    checkOutput("tp4 loss pll_ready", 32'(busIf.pll_ready), 32'h0);
    checkOutput("tp4 loss count", 32'(busIf.lock_lost_cnt), 32'h1);
    checkOutput("tp4 loss state", 32'(busIf.state), 32'h0);
    applyStimulus(1, 0, 11);
    checkOutput("tp4 relock edge13", 32'(busIf.rst_out), 32'hF);
    stepCycle();
    checkOutput("tp4 relock edge14", 32'(busIf.rst_out), 32'hE);
    applyStimulus(1, 0, 11);
    stepCycle();
    checkOutput("tp4 relock edge26 ready", 32'(busIf.pll_ready), 32'h1);

    // Saturation, then reset in the middle of RELEASE
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 1);
      applyStimulus(1, 0, 30);
    end
    checkOutput("tp5 saturated count", 32'(busIf.lock_lost_cnt), 32'd15);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 16);
    checkOutput("tp5 mid release", 32'(busIf.state), 32'h2);
    applyStimulus(1, 1, 1);
    checkOutput("tp5 rst rst_out", 32'(busIf.rst_out), 32'hF);
    checkOutput("tp5 rst pll_ready", 32'(busIf.pll_ready), 32'h0);
    checkOutput("tp5 rst count", 32'(busIf.lock_lost_cnt), 32'h0);
    checkOutput("tp5 rst state", 32'(busIf.state), 32'h0);

`ifdef PLL_AUTO_RESET_EN
    applyStimulus(0, 1, 2);
    applyStimulus(0, 0, 39);
    checkOutput("tp6 edge39 pll_rst", 32'(busIf.pll_rst), 32'h0);
    stepCycle();
    checkOutput("tp6 edge40 pll_rst", 32'(busIf.pll_rst), 32'h1);
    applyStimulus(0, 0, 2);
    checkOutput("tp6 edge42 pll_rst", 32'(busIf.pll_rst), 32'h1);
    stepCycle();
    checkOutput("tp6 edge43 pll_rst", 32'(busIf.pll_rst), 32'h0);
    applyStimulus(0, 0, 39);
    checkOutput("tp6 edge82 pll_rst", 32'(busIf.pll_rst), 32'h0);
    stepCycle();
    checkOutput("tp6 edge83 pll_rst", 32'(busIf.pll_rst), 32'h1);

    applyStimulus(0, 1, 2);
    applyStimulus(0, 0, 40);
    busIf.lock = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("tp6 midpulse edge42", 32'(busIf.pll_rst), 32'h1);
    stepCycle();
    checkOutput("tp6 midpulse edge43", 32'(busIf.pll_rst), 32'h0);
    checkOutput("tp6 midpulse state", 32'(busIf.state), 32'h1);
`endif

    applyStimulus(0, 1, 2);
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        applyStimulus(bit'($urandom_range(0, 1)), 1, int'($urandom_range(1, 3)));
      end else if (r < 11) begin
        if ($urandom_range(0, 1) == 0) applyStimulus(1, 0, int'($urandom_range(1, 12)));
        else applyStimulus(1, 0, int'($urandom_range(20, 40)));
      end else begin
        if ($urandom_range(0, 5) != 0) applyStimulus(0, 0, int'($urandom_range(1, 4)));
        else applyStimulus(0, 0, int'($urandom_range(30, 60)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sits directly downstream of the PLL. Consumes the PLL `lock` output and produces the staged, lock-qualified resets for logic clocked by clkout0..clkout3.
- Synchronizes and debounces `lock`, then releases NUM_STAGES reset lines in a fixed order, one every STAGE_GAP cycles.
- On loss of lock, re-asserts all resets immediately and counts the event.
- Runs entirely on sys_clk.

Parameters:
- NUM_STAGES, 4, number of staged reset outputs (1..8).
- STABLE_CYC, 1000, consecutive synchronized-high lock cycles required before release (>=2).
- STAGE_GAP, 16, cycles between successive stage releases (>=1).
- CNT_W, 8, width of the lock-loss event counter.
- TIMEOUT_CYC, 50000, cycles in WAIT_LOCK before PLL reset request (optional feature only).
- PLL_RST_CYC, 10, width of the pll_rst pulse (optional feature only).

Ports:
- sys_clk, in, 1, system clock; also the PLL reference clock.
- sys_rst, in, 1, synchronous active-high reset.
- lock, in, 1, PLL lock, asynchronous to sys_clk.
- rst_out, out, NUM_STAGES, active-high resets; bit 0 releases first.
- pll_ready, out, 1, high when all stages are released and lock is held.
- lock_lost_cnt, out, CNT_W, saturating count of lock losses seen in RELEASE or RUN.
- state, out, 2, current FSM state: 0 WAIT_LOCK, 1 STABLE, 2 RELEASE, 3 RUN.
- pll_rst, out, 1, PLL reset request; present only with the optional feature.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sys_rst is synchronous and active-high.
- Reset values:
  - rst_out = all ones.
  - pll_ready = 0.
  - lock_lost_cnt = 0.
  - state = WAIT_LOCK.
  - pll_rst = 0.
  - Synchronizer flops cleared to 0.
  - All internal counters cleared to 0.
- Synchronizer:
  - Two-flop synchronizer produces lock_s; latency is 2 sys_clk edges.
  - All FSM decisions use lock_s only.
- WAIT_LOCK:
  - rst_out all ones, pll_ready = 0.
  - lock_s = 1 -> STABLE, with stable counter = 1.
- STABLE:
  - The stable counter increments while lock_s = 1.
  - lock_s = 0 -> WAIT_LOCK. No count increment.
  - Counter == STABLE_CYC with lock_s = 1 -> RELEASE, with gap counter = 0.
- RELEASE:
  - The gap counter increments every cycle.
  - rst_out[k] is cleared on the cycle the gap counter reaches (k+1)*STAGE_GAP.
  - rst_out[k] is registered; once cleared it stays cleared while in RELEASE/RUN.
  - On the release of the last stage -> RUN, and pll_ready = 1 on the same edge.
- RUN: holds; all rst_out = 0, pll_ready = 1.
- Lock loss in RELEASE or RUN (lock_s = 0):
  - On the next edge: rst_out all ones, pll_ready = 0, state = WAIT_LOCK.
  - lock_lost_cnt increments, saturating at 2^CNT_W-1.
- Nominal timing:
  - The first rst_out bit clears 2+STABLE_CYC+STAGE_GAP edges after the first edge that samples lock high.
  - The last bit clears at 2+STABLE_CYC+NUM_STAGES*STAGE_GAP.
- lock glitches:
  - Any single-cycle low on lock_s during STABLE restarts debounce from WAIT_LOCK.
  - A glitch shorter than one sys_clk period may be missed. This is acceptable.
- sys_rst mid-operation: returns to reset values on the same edge regardless of state, including clearing lock_lost_cnt.
- Simultaneous events:
  - sys_rst has priority over everything.
  - Lock loss has priority over a stage release in the same cycle.
- Counter widths are sized with $clog2 so that STABLE_CYC, NUM_STAGES*STAGE_GAP and TIMEOUT_CYC never wrap.

Optional Feature:
- Macro: PLL_AUTO_RESET_EN.
- Defined:
  - A timeout counter runs while in WAIT_LOCK and clears on leaving WAIT_LOCK.
  - When it reaches TIMEOUT_CYC, pll_rst goes high for exactly PLL_RST_CYC cycles, then the timeout counter restarts from 0.
  - lock_s rising during the pulse does not truncate it. FSM transitions proceed normally during the pulse.
  - The pll_rst port exists.
- Undefined:
  - No timeout logic and no pll_rst port.
  - WAIT_LOCK waits indefinitely.

Test Plan (NUM_STAGES=4, STABLE_CYC=8, STAGE_GAP=4, CNT_W=4, TIMEOUT_CYC=40, PLL_RST_CYC=3):
1. Reset sequence: sys_rst high 5 cycles -> rst_out=4'b1111, pll_ready=0, lock_lost_cnt=0, state=0.
2. Nominal lock: lock rises and stays high -> release edges counted from the first edge sampling lock high:
   - rst_out[0] clears at edge 14.
   - rst_out[1] at 18, rst_out[2] at 22, rst_out[3] at 26.
   - pll_ready=1 at edge 26; state=3.
3. Debounce glitch: lock high 5 cycles, low 2, then high -> state returns to 0; release timing restarts from the second rise (rst_out[0] at edge 14 after it); lock_lost_cnt stays 0.
4. Loss in RUN: drop lock for 1 cycle -> after synchronizer latency, on one edge: rst_out=4'b1111, pll_ready=0, lock_lost_cnt=1, state=0. Re-lock then repeats the test-2 timing.
5. Counter saturation and reset: 20 lock-loss events from RUN -> lock_lost_cnt=15. Then sys_rst mid-RELEASE -> all outputs return to reset values on the same edge.
6. With PLL_AUTO_RESET_EN:
   - lock held low: pll_rst high for 3 cycles starting at edge 40, then again at edge 83.
   - lock rising mid-pulse: pulse still lasts 3 cycles.
